// File: rtl/alu_pkg.sv
// Shared types for the ALU core: opcode and operand-B select encodings,
// plus the two-state sequencing FSM.
package alu_pkg;

  localparam int OP_WIDTH   = 4;
  localparam int MOVI_WIDTH = 2;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MULT = 4'd2,
    OP_SHR  = 4'd3,
    OP_SHL  = 4'd4,
    OP_ROR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_NOT  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NAND = 4'd11,
    OP_NOR  = 4'd12,
    OP_XNOR = 4'd13,
    OP_INC  = 4'd14,
    OP_DEC  = 4'd15
  } alu_op_t;

  typedef enum logic [MOVI_WIDTH-1:0] {
    MOVI_REG_B = 2'd0,
    MOVI_MEM   = 2'd1,
    MOVI_IMM   = 2'd2,
    MOVI_ZERO  = 2'd3
  } alu_movi_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mult.sv
// Sequential shift-add multiplier: operands loaded on START, one partial
// product per edge, DONE/PRODUCT valid combinationally during the last iteration.
module alu_mult #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  output logic                      DONE,
  output logic [2*DATA_WIDTH-1:0]   PRODUCT
);

  localparam logic [DATA_WIDTH-1:0] CNT_LAST = DATA_WIDTH'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE  = DATA_WIDTH'(1);

  logic [2*DATA_WIDTH-1:0] mcand_q;
  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [2*DATA_WIDTH-1:0] acc_d;
  logic [DATA_WIDTH-1:0]   mplier_q;
  logic [DATA_WIDTH-1:0]   cnt_q;
  logic                    busy_q;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // PRODUCT is the accumulator after the iteration in flight, so the
  // consumer can register it on the same edge that finishes the multiply.
  assign DONE    = busy_q && (cnt_q == CNT_LAST);
  assign PRODUCT = acc_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (START) begin
      mcand_q  <= {{DATA_WIDTH{1'b0}}, A};
      acc_q    <= '0;
      mplier_q <= B;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_ONE;
      if (DONE) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_core.sv
// ALU core: operand-B mux, single-cycle op logic, IDLE/MUL sequencing FSM
// and registered result/valid/ready outputs.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ACT,
  input  logic [OP_WIDTH-1:0]       OP,
  input  logic [MOVI_WIDTH-1:0]     MOVI,
  input  logic [DATA_WIDTH-1:0]     REG_A,
  input  logic [DATA_WIDTH-1:0]     REG_B,
  input  logic [DATA_WIDTH-1:0]     MEM,
  input  logic [DATA_WIDTH-1:0]     IMM,
  output logic                      ALU_RDY,
  output logic [2*DATA_WIDTH-1:0]   EX_ALU,
  output logic                      EX_ALU_VLD
);

  localparam int N = DATA_WIDTH;
  localparam logic [N:0] ONE_EXT = (N+1)'(1);

  alu_state_t      state_q;
  logic            rdy_q;
  logic            vld_q;
  logic [2*N-1:0]  ex_alu_q;

  alu_op_t         op_c;
  logic [N-1:0]    b_c;
  logic [N:0]      res_c;
  logic            accept_c;
  logic            mult_start_c;
  logic            mult_done_c;
  logic [2*N-1:0]  mult_product_c;

  assign op_c         = alu_op_t'(OP);
  assign accept_c     = ACT && rdy_q;
  assign mult_start_c = accept_c && (state_q == IDLE) && (op_c == OP_MULT);

  always_comb begin
    b_c = '0;
    case (alu_movi_t'(MOVI))
      MOVI_REG_B: b_c = REG_B;
      MOVI_MEM:   b_c = MEM;
      MOVI_IMM:   b_c = IMM;
      MOVI_ZERO:  b_c = '0;
      default:    b_c = '0;
    endcase
  end

  // Arithmetic ops keep N+1 bits so carry/borrow land in bit N.
  always_comb begin
    res_c = '0;
    case (op_c)
      OP_ADD:  res_c = {1'b0, REG_A} + {1'b0, b_c};
      OP_SUB:  res_c = {1'b0, REG_A} - {1'b0, b_c};
      OP_SHR:  res_c = {1'b0, REG_A >> 1};
      OP_SHL:  res_c = {REG_A, 1'b0};
      OP_ROR:  res_c = {1'b0, REG_A[0], REG_A[N-1:1]};
      OP_ROL:  res_c = {1'b0, REG_A[N-2:0], REG_A[N-1]};
      OP_NOT:  res_c = {1'b0, ~REG_A};
      OP_AND:  res_c = {1'b0, REG_A & b_c};
      OP_OR:   res_c = {1'b0, REG_A | b_c};
      OP_XOR:  res_c = {1'b0, REG_A ^ b_c};
      OP_NAND: res_c = {1'b0, ~(REG_A & b_c)};
      OP_NOR:  res_c = {1'b0, ~(REG_A | b_c)};
      OP_XNOR: res_c = {1'b0, ~(REG_A ^ b_c)};
      OP_INC:  res_c = {1'b0, REG_A} + ONE_EXT;
      OP_DEC:  res_c = {1'b0, REG_A} - ONE_EXT;
      default: res_c = '0;
    endcase
  end

  alu_mult #(
    .DATA_WIDTH (N)
  ) u_mult (
    .CLK     (CLK),
    .RST     (RST),
    .START   (mult_start_c),
    .A       (REG_A),
    .B       (b_c),
    .DONE    (mult_done_c),
    .PRODUCT (mult_product_c)
  );

  // Ready drops on the MULT accept edge and returns with the product.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      ex_alu_q <= '0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept_c) begin
            if (op_c == OP_MULT) begin
              state_q <= MUL;
              rdy_q   <= 1'b0;
            end else begin
              ex_alu_q <= {{(N-1){1'b0}}, res_c};
              vld_q    <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mult_done_c) begin
            ex_alu_q <= mult_product_c;
            vld_q    <= 1'b1;
            rdy_q    <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ALU_RDY    = rdy_q;
  assign EX_ALU     = ex_alu_q;
  assign EX_ALU_VLD = vld_q;

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed vector table, hand-written MULT stall/abort
// sequences and randomized transactions against an arithmetic reference model.
module tb_alu_core;

  logic        CLK;
  logic        RST;
  logic        ACT;
  logic [3:0]  OP;
  logic [1:0]  MOVI;
  logic [7:0]  REG_A;
  logic [7:0]  REG_B;
  logic [7:0]  MEM;
  logic [7:0]  IMM;
  logic        ALU_RDY;
  logic [15:0] EX_ALU;
  logic        EX_ALU_VLD;

  int total;
  int bad;

  alu_core #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ACT        (ACT),
    .OP         (OP),
    .MOVI       (MOVI),
    .REG_A      (REG_A),
    .REG_B      (REG_B),
    .MEM        (MEM),
    .IMM        (IMM),
    .ALU_RDY    (ALU_RDY),
    .EX_ALU     (EX_ALU),
    .EX_ALU_VLD (EX_ALU_VLD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  movi;
    logic [7:0]  a;
    logic [7:0]  rb;
    logic [7:0]  mem;
    logic [7:0]  imm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_b(int movi, int rb, int mem, int imm);
    case (movi)
      0: return rb;
      1: return mem;
      2: return imm;
      default: return 0;
    endcase
  endfunction

  function automatic int model(int op, int a, int b);
    case (op)
      0:  return a + b;
      1:  return (a - b + 512) % 512;
      2:  return a * b;
      3:  return a / 2;
      4:  return a * 2;
      5:  return a / 2 + (a % 2) * 128;
      6:  return (a * 2) % 256 + a / 128;
      7:  return 255 - a;
      8:  return a & b;
      9:  return a | b;
      10: return a ^ b;
      11: return 255 - (a & b);
      12: return 255 - (a | b);
      13: return 255 - (a ^ b);
      14: return a + 1;
      15: return (a + 511) % 512;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input vec_t v);
    OP    = v.op;
    MOVI  = v.movi;
    REG_A = v.a;
    REG_B = v.rb;
    MEM   = v.mem;
    IMM   = v.imm;
  endtask

  initial begin
    int op, movi, a, rb, mem, imm, exp, lat;
    total = 0;
    bad   = 0;
    RST = 1'b1; ACT = 1'b0; OP = '0; MOVI = '0;
    REG_A = '0; REG_B = '0; MEM = '0; IMM = '0;

    vecs[0]  = '{4'd0,  2'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 16'h0100};
    vecs[1]  = '{4'd1,  2'd2, 8'h00, 8'h00, 8'h00, 8'h01, 16'h01FF};
    vecs[2]  = '{4'd10, 2'd1, 8'hAA, 8'h00, 8'h0F, 8'h00, 16'h00A5};
    vecs[3]  = '{4'd6,  2'd0, 8'h81, 8'h00, 8'h00, 8'h00, 16'h0003};
    vecs[4]  = '{4'd15, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 16'h01FF};
    vecs[5]  = '{4'd9,  2'd3, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 16'h005A};
    vecs[6]  = '{4'd14, 2'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 16'h0100};
    vecs[7]  = '{4'd3,  2'd0, 8'h01, 8'h00, 8'h00, 8'h00, 16'h0000};
    vecs[8]  = '{4'd4,  2'd0, 8'h80, 8'h00, 8'h00, 8'h00, 16'h0100};
    vecs[9]  = '{4'd5,  2'd0, 8'h01, 8'h00, 8'h00, 8'h00, 16'h0080};
    vecs[10] = '{4'd7,  2'd0, 8'h0F, 8'h00, 8'h00, 8'h00, 16'h00F0};
    vecs[11] = '{4'd8,  2'd0, 8'hF0, 8'h3C, 8'h00, 8'h00, 16'h0030};
    vecs[12] = '{4'd11, 2'd0, 8'hF0, 8'h3C, 8'h00, 8'h00, 16'h00CF};
    vecs[13] = '{4'd12, 2'd0, 8'hF0, 8'h3C, 8'h00, 8'h00, 16'h0003};
    vecs[14] = '{4'd13, 2'd0, 8'hF0, 8'h3C, 8'h00, 8'h00, 16'h0033};
    vecs[15] = '{4'd1,  2'd0, 8'h05, 8'h07, 8'h00, 8'h00, 16'h01FE};
    vecs[16] = '{4'd0,  2'd3, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 16'h007F};

    // Reset and release
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rdy", {15'b0, ALU_RDY}, 16'd0);
      chk("rst_vld", {15'b0, EX_ALU_VLD}, 16'd0);
      chk("rst_ex", EX_ALU, 16'h0000);
    end
    RST = 1'b0;
    tick();
    chk("rel_rdy", {15'b0, ALU_RDY}, 16'd1);
    chk("rel_vld", {15'b0, EX_ALU_VLD}, 16'd0);
    chk("rel_ex", EX_ALU, 16'h0000);

    // Directed table, applied back-to-back with ACT held high
    ACT = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("vec%0d_vld", i), {15'b0, EX_ALU_VLD}, 16'd1);
      chk($sformatf("vec%0d_ex", i), EX_ALU, vecs[i].exp);
      chk($sformatf("vec%0d_rdy", i), {15'b0, ALU_RDY}, 16'd1);
    end
    ACT = 1'b0;
    tick();
    chk("idle_vld", {15'b0, EX_ALU_VLD}, 16'd0);

    // MULT 0xFF*0xFF with an ADD request held during the stall
    OP = 4'd2; MOVI = 2'd0; REG_A = 8'hFF; REG_B = 8'hFF; ACT = 1'b1;
    tick();
    OP = 4'd0; REG_A = 8'h01; REG_B = 8'h01;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("mul_stall%0d_rdy", i), {15'b0, ALU_RDY}, 16'd0);
      chk($sformatf("mul_stall%0d_vld", i), {15'b0, EX_ALU_VLD}, 16'd0);
      tick();
    end
    chk("mul_vld", {15'b0, EX_ALU_VLD}, 16'd1);
    chk("mul_ex", EX_ALU, 16'hFE01);
    chk("mul_rdy", {15'b0, ALU_RDY}, 16'd1);
    ACT = 1'b0;
    tick();
    chk("mul_pulse_end", {15'b0, EX_ALU_VLD}, 16'd0);

    // MULT aborted by reset during iteration 4
    OP = 4'd2; REG_A = 8'h12; REG_B = 8'h34; ACT = 1'b1;
    tick();
    ACT = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort_rdy", {15'b0, ALU_RDY}, 16'd0);
      chk("abort_vld", {15'b0, EX_ALU_VLD}, 16'd0);
    end
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_vld", {15'b0, EX_ALU_VLD}, 16'd0);
    end
    chk("abort_rdy_back", {15'b0, ALU_RDY}, 16'd1);
    OP = 4'd0; MOVI = 2'd0; REG_A = 8'h02; REG_B = 8'h03; ACT = 1'b1;
    tick();
    ACT = 1'b0;
    chk("post_abort_vld", {15'b0, EX_ALU_VLD}, 16'd1);
    chk("post_abort_ex", EX_ALU, 16'h0005);
    tick();

    // Randomized transactions against the reference model
    for (int t = 0; t < 200; t++) begin
      op   = int'($urandom_range(0, 15));
      movi = int'($urandom_range(0, 3));
      a    = int'($urandom_range(0, 255));
      rb   = int'($urandom_range(0, 255));
      mem  = int'($urandom_range(0, 255));
      imm  = int'($urandom_range(0, 255));
      if (t % 8 == 0) a = 255;
      if (t % 11 == 0) begin rb = 255; mem = 255; imm = 255; end
      exp = model(op, a, pick_b(movi, rb, mem, imm));
      chk("rnd_rdy", {15'b0, ALU_RDY}, 16'd1);
      OP = 4'(op); MOVI = 2'(movi); REG_A = 8'(a);
      REG_B = 8'(rb); MEM = 8'(mem); IMM = 8'(imm);
      ACT = 1'b1;
      tick();
      ACT = 1'b0;
      lat = 1;
      while (!EX_ALU_VLD && lat < 20) begin
        OP = 4'($urandom); REG_A = 8'($urandom); REG_B = 8'($urandom);
        MEM = 8'($urandom); IMM = 8'($urandom); MOVI = 2'($urandom);
        tick();
        lat++;
      end
      chk("rnd_vld", {15'b0, EX_ALU_VLD}, 16'd1);
      chk("rnd_latency", 16'(lat), (op == 2) ? 16'd9 : 16'd1);
      chk($sformatf("rnd_op%0d_ex", op), EX_ALU, 16'(exp));
      tick();
      chk("rnd_pulse_end", {15'b0, EX_ALU_VLD}, 16'd0);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Synthesizable ALU DUT that consumes the operand/opcode transactions the ALU driver applies from the sequence layer.
- Produces results, with a valid strobe, to the output monitor.
- Single-cycle logic and bitwise ops run at one per cycle. MULT is a sequential shift-add that stalls the input handshake while busy.

Parameters:
- DATA_WIDTH, 8, operand width N; result width is 2N.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ACT  in  1  transaction request.
- OP  in  4  opcode.
- MOVI  in  2  operand-B select: 00 REG_B, 01 MEM, 10 IMM, 11 constant zero.
- REG_A  in  N  operand A.
- REG_B  in  N  operand B source.
- MEM  in  N  operand B source.
- IMM  in  N  operand B source.
- ALU_RDY  out  1  ready to accept a transaction.
- EX_ALU  out  2N  result.
- EX_ALU_VLD  out  1  result valid, one-cycle pulse per transaction.

Behaviour:
- Clocking and reset (fixed): one clock, CLK; reset RST is synchronous and active-high.
- While RST=1 at an edge: ALU_RDY=0, EX_ALU=0, EX_ALU_VLD=0, FSM=IDLE, multiplier cleared.
- ALU_RDY rises at the first edge with RST=0.
- Reset asserted mid-MULT aborts it; no result is emitted.
- Accept: transaction taken at an edge where ACT=1 && ALU_RDY=1. ACT while ALU_RDY=0 is ignored, not queued.
- Operand B is chosen by MOVI at accept. A, B and OP are latched at accept; later input changes are ignored.
- Opcodes and results (results zero-extended to 2N):
  - 0 ADD: A+B, N+1 bits; carry lands in bit N.
  - 1 SUB: A-B mod 2^(N+1); borrow shows in bit N.
  - 2 MULT: A*B, full 2N bits.
  - 3 SHR: A>>1, logical.
  - 4 SHL: A<<1, N+1 bits.
  - 5 ROR: rotate A right by 1, N bits.
  - 6 ROL: rotate A left by 1, N bits.
  - 7 NOT: ~A.
  - 8 AND, 9 OR, 10 XOR, 11 NAND, 12 NOR, 13 XNOR: bitwise A op B, N bits.
  - 14 INC: A+1, N+1 bits (0xFF→0x100).
  - 15 DEC: A-1 mod 2^(N+1) (0x00→0x1FF).
- Single-cycle ops (all except MULT):
  - Result registered at the accept edge k; EX_ALU_VLD=1 in cycle k+1 only.
  - ALU_RDY stays 1, so back-to-back accepts give back-to-back VLD pulses.
- FSM states: IDLE and MUL.
  - IDLE→MUL on accepting OP=2. ALU_RDY is registered 0 at the same edge k.
  - In MUL: one shift-add iteration per edge; an N-bit counter runs from 0 to N-1.
  - At edge k+N, i.e. the final iteration, the product is registered to EX_ALU, EX_ALU_VLD=1 and ALU_RDY=1, and the FSM returns to IDLE.
  - Result visible in cycle k+N+1. Next accept is possible at edge k+N+1.
- EX_ALU holds its last value when EX_ALU_VLD=0; the bench checks it only on VLD.
- MOVI=11 gives B=0 for every B-using opcode.
- No simultaneous-event ambiguity: only one operation is ever in flight besides the single-cycle output register.

Decomposition:
- alu_pkg holds:
  - enum alu_op_t (ADD..DEC, 4-bit encodings above);
  - enum alu_movi_t;
  - enum alu_state_t {IDLE, MUL};
  - localparam OP_WIDTH=4, MOVI_WIDTH=2.
- One sub-module, alu_mult: sequential shift-add multiplier.
  - Ports: CLK, RST, START, A, B, DONE, PRODUCT.
  - DONE is a one-cycle pulse N edges after START.
- alu_core holds the operand mux, combinational op logic, FSM and output registers.

Test Plan (N=8):
- Reset release → ALU_RDY=0 during reset, 1 one edge after RST falls; EX_ALU_VLD=0 throughout; EX_ALU=0x0000.
- ADD A=0xFF, REG_B=0x01, MOVI=00 → VLD next cycle, EX_ALU=0x0100. SUB A=0x00, IMM=0x01, MOVI=10 → EX_ALU=0x01FF.
- Back-to-back: XOR(0xAA,MEM=0x0F), ROL(0x81), DEC(0x00) on consecutive cycles → three consecutive VLD pulses with 0x00A5, 0x0003, 0x01FF; ALU_RDY constant 1.
- MULT A=0xFF, B=0xFF accepted at edge k:
  - ALU_RDY=0 in cycles k+1..k+8;
  - ACT with ADD during the stall is ignored (no extra VLD);
  - VLD in cycle k+9 only, with EX_ALU=0xFE01.
- MULT accepted, then RST=1 at iteration 4 → no VLD, ALU_RDY=0 during reset. Post-reset ADD(0x02,0x03) → EX_ALU=0x0005.
- MOVI=11 with OR A=0x5A, REG_B=MEM=IMM=0xFF → EX_ALU=0x005A. INC 0xFF → 0x0100. SHR 0x01 → 0x0000.
